// File: rtl/seg7_pkg.sv
// Shared glyphs (active-low abcdefg, bit6=a) and display mode encodings
// for the temperature seven-segment display.
package seg7_pkg;

  typedef enum logic [1:0] {
    MODE_C    = 2'b00,
    MODE_F    = 2'b01,
    MODE_BOTH = 2'b10,
    MODE_ALT  = 2'b11
  } mode_e;

  localparam logic [6:0] GLYPH_0     = 7'b000_0001;
  localparam logic [6:0] GLYPH_1     = 7'b100_1111;
  localparam logic [6:0] GLYPH_2     = 7'b001_0010;
  localparam logic [6:0] GLYPH_3     = 7'b000_0110;
  localparam logic [6:0] GLYPH_4     = 7'b100_1100;
  localparam logic [6:0] GLYPH_5     = 7'b010_0100;
  localparam logic [6:0] GLYPH_6     = 7'b010_0000;
  localparam logic [6:0] GLYPH_7     = 7'b000_1111;
  localparam logic [6:0] GLYPH_8     = 7'b000_0000;
  localparam logic [6:0] GLYPH_9     = 7'b000_0100;
  localparam logic [6:0] GLYPH_C     = 7'b011_0001;
  localparam logic [6:0] GLYPH_F     = 7'b011_1000;
  localparam logic [6:0] GLYPH_DEG   = 7'b001_1100;
  localparam logic [6:0] GLYPH_DASH  = 7'b111_1110;
  localparam logic [6:0] GLYPH_BLANK = 7'b111_1111;

  function automatic logic [6:0] digit_glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = GLYPH_0;
      4'd1:    g = GLYPH_1;
      4'd2:    g = GLYPH_2;
      4'd3:    g = GLYPH_3;
      4'd4:    g = GLYPH_4;
      4'd5:    g = GLYPH_5;
      4'd6:    g = GLYPH_6;
      4'd7:    g = GLYPH_7;
      4'd8:    g = GLYPH_8;
      4'd9:    g = GLYPH_9;
      default: g = GLYPH_BLANK;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to 3-digit BCD converter; the load cycle
// performs the first shift so exactly DATA_W cycles elapse from start to done.
//
// state | meaning
// IDLE  | waiting for start; load performs shift 1
// SHIFT | shifts 2..DATA_W, one per cycle
// DONE  | done high for this one cycle, result held on outputs
module bin2bcd_seq #(
  parameter int DATA_W = 8
) (
  input  logic              clk_100MHz,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] bin,
  output logic              done,
  output logic [3:0]        bcd_hund,
  output logic [3:0]        bcd_tens,
  output logic [3:0]        bcd_ones
);

  localparam int CW = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e            state_q;
  logic [11:0]       bcd_q;
  logic [DATA_W-1:0] sr_q;
  logic [CW-1:0]     cnt_q;

  logic [11:0]       seed_bcd;
  logic [DATA_W-1:0] seed_sr;
  logic [11:0]       adj_bcd;
  logic [11:0]       next_bcd;
  logic [DATA_W-1:0] next_sr;

  always_comb begin
    seed_bcd = (state_q == IDLE) ? 12'd0 : bcd_q;
    seed_sr  = (state_q == IDLE) ? bin : sr_q;
    adj_bcd  = seed_bcd;
    for (int i = 0; i < 3; i++) begin
      if (seed_bcd[4*i +: 4] >= 4'd5)
        adj_bcd[4*i +: 4] = seed_bcd[4*i +: 4] + 4'd3;
    end
    next_bcd = {adj_bcd[10:0], seed_sr[DATA_W-1]};
    next_sr  = {seed_sr[DATA_W-2:0], 1'b0};
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state_q <= IDLE;
      done    <= 1'b0;
      bcd_q   <= '0;
      sr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            bcd_q   <= next_bcd;
            sr_q    <= next_sr;
            cnt_q   <= CW'(1);
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_q <= next_bcd;
          sr_q  <= next_sr;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(DATA_W - 1)) begin
            state_q <= DONE;
            done    <= 1'b1;
          end
        end
        DONE: begin
          done    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bcd_hund = bcd_q[11:8];
  assign bcd_tens = bcd_q[7:4];
  assign bcd_ones = bcd_q[3:0];

endmodule

// File: rtl/seg7_temp_display.sv
// Latches signed C/F readings, converts them to BCD and multiplexes them onto
// an 8-digit active-low seven-segment display in one of four modes.
//
// state   | meaning
// IDLE    | shadows valid, waiting for data_valid
// CONVERT | both BCD converters running, busy high, new strobes dropped
module seg7_temp_display
  import seg7_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int DIGIT_PERIOD = 100_000,
  parameter int ALT_PERIOD   = 300_000_000
) (
  input  logic              clk_100MHz,
  input  logic              reset,
  input  logic [DATA_W-1:0] c_data,
  input  logic [DATA_W-1:0] f_data,
  input  logic              data_valid,
  input  logic [1:0]        mode,
  output logic              busy,
  output logic [6:0]        SEG,
  output logic [7:0]        AN
);

  localparam int RW = (DIGIT_PERIOD > 1) ? $clog2(DIGIT_PERIOD) : 1;
  localparam int AW = (ALT_PERIOD > 1) ? $clog2(ALT_PERIOD) : 1;

  typedef enum logic {IDLE, CONVERT} samp_state_e;

  samp_state_e       state_q;
  logic              start;
  logic [DATA_W-1:0] c_mag, f_mag;
  logic              done_c, done_f;
  logic [3:0]        c_hund, c_tens, c_ones, f_hund, f_tens, f_ones;
  logic              c_neg_p, f_neg_p;
  logic              c_neg_q, f_neg_q;
  logic [3:0]        c_hund_q, c_tens_q, c_ones_q, f_hund_q, f_tens_q, f_ones_q;

  logic [RW-1:0]     refresh_cnt;
  logic [2:0]        digit_idx;
  logic [AW-1:0]     alt_cnt;
  logic              alt_f;
  logic [1:0]        mode_q;

  assign start = (state_q == IDLE) && data_valid;
  assign c_mag = c_data[DATA_W-1] ? (~c_data + DATA_W'(1)) : c_data;
  assign f_mag = f_data[DATA_W-1] ? (~f_data + DATA_W'(1)) : f_data;

  bin2bcd_seq #(.DATA_W(DATA_W)) u_bcd_c (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .start      (start),
    .bin        (c_mag),
    .done       (done_c),
    .bcd_hund   (c_hund),
    .bcd_tens   (c_tens),
    .bcd_ones   (c_ones)
  );

  bin2bcd_seq #(.DATA_W(DATA_W)) u_bcd_f (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .start      (start),
    .bin        (f_mag),
    .done       (done_f),
    .bcd_hund   (f_hund),
    .bcd_tens   (f_tens),
    .bcd_ones   (f_ones)
  );

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state_q  <= IDLE;
      busy     <= 1'b0;
      c_neg_p  <= 1'b0;
      f_neg_p  <= 1'b0;
      c_neg_q  <= 1'b0;
      f_neg_q  <= 1'b0;
      c_hund_q <= '0;
      c_tens_q <= '0;
      c_ones_q <= '0;
      f_hund_q <= '0;
      f_tens_q <= '0;
      f_ones_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (data_valid) begin
            state_q <= CONVERT;
            busy    <= 1'b1;
            c_neg_p <= c_data[DATA_W-1];
            f_neg_p <= f_data[DATA_W-1];
          end
        end
        CONVERT: begin
          // Both shadows load together so the display never mixes readings.
          if (done_c && done_f) begin
            state_q  <= IDLE;
            busy     <= 1'b0;
            c_neg_q  <= c_neg_p;
            f_neg_q  <= f_neg_p;
            c_hund_q <= c_hund;
            c_tens_q <= c_tens;
            c_ones_q <= c_ones;
            f_hund_q <= f_hund;
            f_tens_q <= f_tens;
            f_ones_q <= f_ones;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      refresh_cnt <= '0;
      digit_idx   <= '0;
    end else if (refresh_cnt == RW'(DIGIT_PERIOD - 1)) begin
      refresh_cnt <= '0;
      digit_idx   <= digit_idx + 3'd1;
    end else begin
      refresh_cnt <= refresh_cnt + RW'(1);
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      alt_cnt <= '0;
      alt_f   <= 1'b0;
      mode_q  <= mode;
    end else begin
      mode_q <= mode;
      if ((mode != mode_q) || (mode != MODE_ALT)) begin
        alt_cnt <= '0;
        alt_f   <= 1'b0;
      end else if (alt_cnt == AW'(ALT_PERIOD - 1)) begin
        alt_cnt <= '0;
        alt_f   <= ~alt_f;
      end else begin
        alt_cnt <= alt_cnt + AW'(1);
      end
    end
  end

  logic       use_f;
  logic       s_neg;
  logic [3:0] s_hund, s_tens, s_ones;
  logic [6:0] s_unit;
  logic       c_ok, f_ok;
  logic [6:0] seg_next;

  always_comb begin
    // On the cycle ALT is first selected the alternation state is stale; show C.
    case (mode)
      MODE_F:              use_f = 1'b1;
      MODE_ALT:            use_f = (mode_q == MODE_ALT) && alt_f;
      MODE_C, MODE_BOTH:   use_f = 1'b0;
      default:             use_f = 1'b0;
    endcase
    s_neg  = use_f ? f_neg_q  : c_neg_q;
    s_hund = use_f ? f_hund_q : c_hund_q;
    s_tens = use_f ? f_tens_q : c_tens_q;
    s_ones = use_f ? f_ones_q : c_ones_q;
    s_unit = use_f ? GLYPH_F  : GLYPH_C;
    c_ok   = !c_neg_q && (c_hund_q == 4'd0);
    f_ok   = !f_neg_q && (f_hund_q == 4'd0);

    seg_next = GLYPH_BLANK;
    if (mode == MODE_BOTH) begin
      case (digit_idx)
        3'd0: seg_next = GLYPH_C;
        3'd1: seg_next = GLYPH_DEG;
        3'd2: seg_next = c_ok ? digit_glyph(c_ones_q) : GLYPH_DASH;
        3'd3: seg_next = !c_ok ? GLYPH_DASH :
                         (c_tens_q == 4'd0) ? GLYPH_BLANK : digit_glyph(c_tens_q);
        3'd4: seg_next = GLYPH_F;
        3'd5: seg_next = GLYPH_DEG;
        3'd6: seg_next = f_ok ? digit_glyph(f_ones_q) : GLYPH_DASH;
        3'd7: seg_next = !f_ok ? GLYPH_DASH :
                         (f_tens_q == 4'd0) ? GLYPH_BLANK : digit_glyph(f_tens_q);
        default: seg_next = GLYPH_BLANK;
      endcase
    end else begin
      case (digit_idx)
        3'd0: seg_next = s_unit;
        3'd1: seg_next = GLYPH_DEG;
        3'd2: seg_next = digit_glyph(s_ones);
        3'd3: seg_next = ((s_hund == 4'd0) && (s_tens == 4'd0)) ? GLYPH_BLANK
                                                                : digit_glyph(s_tens);
        3'd4: seg_next = (s_hund == 4'd0) ? GLYPH_BLANK : digit_glyph(s_hund);
        3'd5: seg_next = s_neg ? GLYPH_DASH : GLYPH_BLANK;
        default: seg_next = GLYPH_BLANK;
      endcase
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      SEG <= 7'b111_1111;
      AN  <= 8'hFF;
    end else begin
      SEG <= seg_next;
      AN  <= ~(8'd1 << digit_idx);
    end
  end

endmodule
